// File: rtl/id_stage_reg_pkg.sv
// rtl/id_stage_reg_pkg.sv - RV32I decode types, opcode/funct constants and ALU op helper
package id_stage_reg_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam logic [6:0] RV32I_OP_IMM   = 7'b0010011;
  localparam logic [6:0] RV32I_OP_R     = 7'b0110011;
  localparam logic [6:0] RV32I_OP_LUI   = 7'b0110111;
  localparam logic [6:0] RV32I_OP_AUIPC = 7'b0010111;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  typedef enum logic [1:0] {
    OP1_ZERO = 2'd0,
    OP1_RS1  = 2'd1,
    OP1_PC   = 2'd2
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_ZERO = 2'd0,
    OP2_RS2  = 2'd1,
    OP2_IMM  = 2'd2
  } op2_sel_e;

  typedef struct packed {
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        illegal;
  } decode_t;

  // alt selects the funct7=0x20 variant; it only changes ADD and SRL.
  function automatic alu_op_e funct3_to_alu(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  op = ALU_SLL;
      F3_SLT:  op = ALU_SLT;
      F3_SLTU: op = ALU_SLTU;
      F3_XOR:  op = ALU_XOR;
      F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/id_stage_reg_decode_core.sv
// rtl/id_stage_reg_decode_core.sv - combinational RV32I decode: operand selects, immediate, alu op, rd, legality
module id_decode_core
  import id_stage_reg_pkg::*;
#(
  parameter bit EN_RTYPE = 1'b1,
  parameter bit EN_UPPER = 1'b1
) (
  input  logic [31:0] instr,
  output decode_t     dec
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        illegal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.op1_sel = OP1_ZERO;
    dec.op2_sel = OP2_ZERO;
    dec.alu_op  = ALU_ADD;
    dec.rd      = instr[11:7];
    illegal     = 1'b0;

    case (opcode)
      RV32I_OP_IMM: begin
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_i;
        dec.alu_op  = funct3_to_alu(funct3, 1'b0);
        if (funct3 == F3_SLL) begin
          dec.imm = shamt;
          illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          dec.imm    = shamt;
          dec.alu_op = funct3_to_alu(funct3, funct7 == F7_ALT);
          illegal    = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
      end
      RV32I_OP_R: begin
        dec.op1_sel = OP1_RS1;
        dec.op2_sel = OP2_RS2;
        if (!EN_RTYPE) begin
          illegal = 1'b1;
        end else if (funct7 == F7_BASE) begin
          dec.alu_op = funct3_to_alu(funct3, 1'b0);
        end else if (funct7 == F7_ALT && (funct3 == F3_ADD || funct3 == F3_SR)) begin
          dec.alu_op = funct3_to_alu(funct3, 1'b1);
        end else begin
          illegal = 1'b1;
        end
      end
      RV32I_OP_LUI: begin
        dec.op1_sel = OP1_ZERO;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
        illegal     = !EN_UPPER;
      end
      RV32I_OP_AUIPC: begin
        dec.op1_sel = OP1_PC;
        dec.op2_sel = OP2_IMM;
        dec.imm     = imm_u;
        illegal     = !EN_UPPER;
      end
      default: illegal = 1'b1;
    endcase

    // An illegal entry still travels to EX so it can trap; it must carry no side effects.
    if (illegal) begin
      dec.op1_sel = OP1_ZERO;
      dec.op2_sel = OP2_ZERO;
      dec.imm     = '0;
      dec.alu_op  = ALU_ADD;
    end
    dec.illegal = illegal;
    dec.reg_wen = !illegal && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/id_stage_reg.sv
// rtl/id_stage_reg.sv - registered RV32I decode stage with WB bypass and valid/ready ID/EX register
module id_stage_reg
  import id_stage_reg_pkg::*;
#(
  parameter bit EN_RTYPE  = 1'b1,
  parameter bit EN_UPPER  = 1'b1,
  parameter bit EN_WB_FWD = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_i,
  input  logic [31:0] instr_addr_i,
  input  logic        flush_i,
  output logic [4:0]  reg1_raddr,
  output logic [4:0]  reg2_raddr,
  input  logic [31:0] reg1_rdata,
  input  logic [31:0] reg2_rdata,
  input  logic        wb_wen,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr_o,
  output logic [31:0] instr_addr_o,
  output logic [31:0] operand1_o,
  output logic [31:0] operand2_o,
  output logic [4:0]  rd_o,
  output logic        reg_wen_o,
  output logic [3:0]  alu_op_o,
  output logic        illegal_o
);

  decode_t     dec;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        load;

  id_decode_core #(
    .EN_RTYPE (EN_RTYPE),
    .EN_UPPER (EN_UPPER)
  ) u_decode (
    .instr (instr_i),
    .dec   (dec)
  );

  assign reg1_raddr = instr_i[19:15];
  assign reg2_raddr = instr_i[24:20];

  // x0 reads as zero even if the regfile or the writeback bus says otherwise.
  function automatic logic [31:0] read_src(
    input logic [4:0]  addr,
    input logic [31:0] rdata,
    input logic        fwd_wen,
    input logic [4:0]  fwd_addr,
    input logic [31:0] fwd_data
  );
    if (addr == 5'd0)
      return 32'd0;
    else if (EN_WB_FWD && fwd_wen && fwd_addr == addr)
      return fwd_data;
    else
      return rdata;
  endfunction

  assign rs1_val = read_src(reg1_raddr, reg1_rdata, wb_wen, wb_waddr, wb_wdata);
  assign rs2_val = read_src(reg2_raddr, reg2_rdata, wb_wen, wb_waddr, wb_wdata);

  always_comb begin
    op1 = 32'd0;
    case (dec.op1_sel)
      OP1_RS1: op1 = rs1_val;
      OP1_PC:  op1 = instr_addr_i;
      default: op1 = 32'd0;
    endcase
  end

  always_comb begin
    op2 = 32'd0;
    case (dec.op2_sel)
      OP2_RS2: op2 = rs2_val;
      OP2_IMM: op2 = dec.imm;
      default: op2 = 32'd0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      instr_o      <= 32'd0;
      instr_addr_o <= 32'd0;
      operand1_o   <= 32'd0;
      operand2_o   <= 32'd0;
      rd_o         <= 5'd0;
      reg_wen_o    <= 1'b0;
      alu_op_o     <= ALU_ADD;
      illegal_o    <= 1'b0;
    end else begin
      if (flush_i)
        out_valid <= 1'b0;
      else if (load)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;

      // Data registers only move on a real load, so a flush leaves stale but harmless values.
      if (load) begin
        instr_o      <= instr_i;
        instr_addr_o <= instr_addr_i;
        operand1_o   <= op1;
        operand2_o   <= op2;
        rd_o         <= dec.rd;
        reg_wen_o    <= dec.reg_wen;
        alu_op_o     <= dec.alu_op;
        illegal_o    <= dec.illegal;
      end
    end
  end

endmodule
